// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width, bit-timing helpers.
// Latency: n/a (package only).
// Backpressure: n/a. Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    // The receiver decodes the same encoding, so PARITY stays in the enum
    // even in builds where the transmitter never enters it.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Clock cycles per bit time; clk_fre_mhz is in MHz, baud in bit/s.
    function automatic int calc_bit_cyc(input int clk_fre_mhz, input int baud);
        return (clk_fre_mhz * 1000000) / baud;
    endfunction

    // Width of a counter that runs 0..bit_cyc-1.
    function automatic int calc_cnt_w(input int bit_cyc);
        return (bit_cyc < 2) ? 1 : $clog2(bit_cyc);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Modulo-CYC cycle counter producing a one-cycle tick on its last count.
// Latency: tick is a decode of the registered count (same cycle as count CYC-1).
// Backpressure: none; clr holds the count at 0 and takes priority over counting.
// Ports: clk, rst_n (sync, active low), clr (restart at 0), tick (count == CYC-1).
module uart_baud_tick #(
    parameter int CYC = 10,
    parameter int W   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    logic [W-1:0] cnt_q;

    assign tick = (cnt_q == W'(CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one byte per valid/ready handshake, idle-high LSB-first frame.
// Latency: start bit appears on tx_pin the cycle after the accepting edge.
// Backpressure: ready only in IDLE or the last cycle of the last stop bit.
// Ports: clk, rst_n (sync, active low), tx_data/tx_data_valid/tx_data_ready (byte
// handshake), tx_busy (frame in progress), tx_pin (registered serial output).
// Build option: define UART_TX_PARITY_EN to insert a parity bit (sense PARITY_ODD).
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FRE    = 200,
    parameter int BAUD_RATE  = 115200,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_data_valid,
    output logic                   tx_data_ready,
    output logic                   tx_busy,
    output logic                   tx_pin
);

    localparam int BIT_CYC = calc_bit_cyc(CLK_FRE, BAUD_RATE);
    localparam int CNT_W   = calc_cnt_w(BIT_CYC);

    if (BIT_CYC < 2) begin : g_bad_bit_cyc
        $error("uart_tx_frame: BIT_CYC must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
    end

    uart_state_t            state_q, state_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   pin_q, pin_d;
    logic                   busy_q;
    logic                   cnt_clr;
    logic                   bit_tick;
    logic                   last_stop;
    logic                   accept;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q;
`endif

    uart_baud_tick #(
        .CYC (BIT_CYC),
        .W   (CNT_W)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .tick  (bit_tick)
    );

    // bit_idx doubles as the stop-bit counter while in STOP.
    assign last_stop     = (state_q == STOP) && bit_tick && (bit_idx_q == 3'(STOP_BITS - 1));
    assign tx_data_ready = (state_q == IDLE) || last_stop;
    assign accept        = tx_data_valid && tx_data_ready;
    assign tx_busy       = busy_q;
    assign tx_pin        = pin_q;

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        cnt_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                // Keep the bit counter parked so START gets a full bit time.
                cnt_clr = 1'b1;
                if (accept) begin
                    state_d   = START;
                    shift_d   = tx_data;
                    bit_idx_d = '0;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_d   = STOP;
                    bit_idx_d = '0;
                end
            end
`endif
            STOP: begin
                if (last_stop) begin
                    if (accept) begin
                        // Back-to-back: next start bit follows with no idle gap.
                        state_d = START;
                        shift_d = tx_data;
                    end else begin
                        state_d = IDLE;
                    end
                    bit_idx_d = '0;
                end else if (bit_tick) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_idx_d = '0;
            end
        endcase
    end

    // Line value is derived from the next state so tx_pin stays registered
    // and changes on the same edge the state does.
    always_comb begin
        pin_d = 1'b1;
        case (state_d)
            START:   pin_d = 1'b0;
            DATA:    pin_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  pin_d = parity_q;
`endif
            default: pin_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            shift_q   <= '0;
            pin_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            pin_q     <= pin_d;
            busy_q    <= (state_d != IDLE);
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is taken from the byte as accepted; tx_data may change afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= (^tx_data) ^ 1'(PARITY_ODD);
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame at BIT_CYC=10 (1 MHz clock, 100 kbit/s).
// dut: STOP_BITS=1, even parity; dut2: STOP_BITS=2, odd parity.
// A line monitor on dut decodes frames and checks them against a byte scoreboard.
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NBITS1 = 10 + PB;
    localparam int LEN1   = NBITS1 * 10;
    localparam int LEN2   = (11 + PB) * 10;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data,  tx_data2;
    logic       tx_data_valid, tx_data_valid2;
    logic       tx_data_ready, tx_data_ready2;
    logic       tx_busy,  tx_busy2;
    logic       tx_pin,   tx_pin2;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] sb_q[$];

    uart_tx_frame #(
        .CLK_FRE    (1),
        .BAUD_RATE  (100000),
        .STOP_BITS  (1),
        .PARITY_ODD (0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .tx_busy       (tx_busy),
        .tx_pin        (tx_pin)
    );

    uart_tx_frame #(
        .CLK_FRE    (1),
        .BAUD_RATE  (100000),
        .STOP_BITS  (2),
        .PARITY_ODD (1)
    ) dut2 (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_data       (tx_data2),
        .tx_data_valid (tx_data_valid2),
        .tx_data_ready (tx_data_ready2),
        .tx_busy       (tx_busy2),
        .tx_pin        (tx_pin2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level during bit time i of a frame carrying d.
    function automatic logic exp_bit(input logic [7:0] d, input int odd, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == 9) return (^d) ^ odd[0];
`else
        if (odd < 0) return 1'bx;
`endif
        return 1'b1;
    endfunction

    // Called at a negedge: offer d and wait for the accepting edge.
    // Returns just after that edge; waited = negedges spent before ready.
    task automatic send(input bit use2, input logic [7:0] d, input bit hold, output int waited);
        bit ok;
        logic rdy;
        ok     = 1'b0;
        waited = 0;
        if (use2) begin
            tx_data2 = d; tx_data_valid2 = 1'b1;
        end else begin
            tx_data = d; tx_data_valid = 1'b1;
        end
        for (int n = 0; n < 400; n++) begin
            rdy = use2 ? tx_data_ready2 : tx_data_ready;
            if (rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
            waited++;
            @(negedge clk);
        end
        if (ok) begin
            if (!use2) sb_q.push_back(d);
            @(posedge clk);
            #1;
        end else begin
            chk("accept_timeout", 32'd0, 32'd1);
        end
        if (!hold || !ok) begin
            if (use2) tx_data_valid2 = 1'b0;
            else      tx_data_valid  = 1'b0;
        end
    endtask

    // Cycle-by-cycle check of a whole frame starting right after acceptance;
    // returns at the negedge of the last frame cycle.
    task automatic check_frame(input bit use2, input logic [7:0] d, input string tag);
        int   len, odd, pin_bad, busy_bad, rdy_bad;
        logic pin, busy, rdy;
        len = use2 ? LEN2 : LEN1;
        odd = use2 ? 1 : 0;
        pin_bad = 0; busy_bad = 0; rdy_bad = 0;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            pin  = use2 ? tx_pin2        : tx_pin;
            busy = use2 ? tx_busy2       : tx_busy;
            rdy  = use2 ? tx_data_ready2 : tx_data_ready;
            if (pin !== exp_bit(d, odd, k / 10)) pin_bad++;
            if (busy !== 1'b1) busy_bad++;
            if (rdy !== (k == len - 1)) rdy_bad++;
        end
        chk({tag, "_pin_errs"},   pin_bad,  0);
        chk({tag, "_busy_errs"},  busy_bad, 0);
        chk({tag, "_ready_errs"}, rdy_bad,  0);
    endtask

    // Line monitor for dut: samples mid-bit and checks against the scoreboard.
    int         mon_k;
    bit         mon_act = 1'b0;
    logic [11:0] mon_bits;
    logic [7:0] mon_exp;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                mon_act = 1'b0;
            end else if (!mon_act) begin
                if (tx_pin === 1'b0) begin
                    mon_act  = 1'b1;
                    mon_k    = 0;
                    mon_bits = '0;
                end
            end else begin
                mon_k++;
                if (mon_k % 10 == 5) begin
                    mon_bits[mon_k / 10] = tx_pin;
                    if (mon_k / 10 == NBITS1 - 1) begin
                        mon_act = 1'b0;
                        if (sb_q.size() == 0) begin
                            chk("mon_unexpected_frame", 32'd1, 32'd0);
                        end else begin
                            mon_exp = sb_q.pop_front();
                            chk("mon_byte", mon_bits[8:1], mon_exp);
                            chk("mon_framing", {mon_bits[0], mon_bits[NBITS1-1]}, 2'b01);
`ifdef UART_TX_PARITY_EN
                            chk("mon_parity", mon_bits[9], ^mon_exp);
`endif
                        end
                    end
                end
            end
        end
    end

    initial begin
        int   waited, toggles, busy_cnt;
        logic prev;

        // Reset, with a handshake offered that must be ignored.
        rst_n = 1'b0;
        tx_data = 8'h5A;  tx_data_valid  = 1'b1;
        tx_data2 = 8'h5A; tx_data_valid2 = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_pin",   tx_pin,        1'b1);
        chk("rst_busy",  tx_busy,       1'b0);
        chk("rst_ready", tx_data_ready, 1'b1);
        tx_data_valid = 1'b0;
        rst_n = 1'b1;

        // Quiet line after release.
        toggles = 0; busy_cnt = 0; prev = tx_pin;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (tx_pin !== prev) toggles++;
            if (tx_busy !== 1'b0) busy_cnt++;
            prev = tx_pin;
        end
        chk("idle_toggles", toggles,  0);
        chk("idle_busy",    busy_cnt, 0);
        chk("idle_pin",     tx_pin,   1'b1);

        // Single byte 0xA3.
        send(1'b0, 8'hA3, 1'b0, waited);
        check_frame(1'b0, 8'hA3, "a3");
        @(negedge clk);
        chk("a3_after_pin",   tx_pin,        1'b1);
        chk("a3_after_busy",  tx_busy,       1'b0);
        chk("a3_after_ready", tx_data_ready, 1'b1);

        // Back-to-back 0x55 then 0x0F with valid held.
        repeat (3) @(negedge clk);
        send(1'b0, 8'h55, 1'b1, waited);
        tx_data = 8'h0F;
        check_frame(1'b0, 8'h55, "b2b_55");
        send(1'b0, 8'h0F, 1'b0, waited);
        chk("b2b_gap_cycles", waited, 0);
        check_frame(1'b0, 8'h0F, "b2b_0f");
        @(negedge clk);
        chk("b2b_after_busy", tx_busy, 1'b0);

        // Two stop bits: 0xFF then 0xA3 held; next acceptance only at cycle 110.
        send(1'b1, 8'hFF, 1'b1, waited);
        tx_data2 = 8'hA3;
        check_frame(1'b1, 8'hFF, "s2_ff");
        send(1'b1, 8'hA3, 1'b0, waited);
        chk("s2_gap_cycles", waited, 0);
        check_frame(1'b1, 8'hA3, "s2_a3");
        @(negedge clk);
        chk("s2_after_busy", tx_busy2, 1'b0);
        chk("s2_after_pin",  tx_pin2,  1'b1);

        // Reset in the middle of a 0x00 frame.
        repeat (2) @(negedge clk);
        send(1'b0, 8'h00, 1'b0, waited);
        for (int k = 0; k < 35; k++) @(negedge clk);
        chk("mid_pin_before_rst", tx_pin, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_pin",   tx_pin,        1'b1);
        chk("mid_rst_busy",  tx_busy,       1'b0);
        chk("mid_rst_ready", tx_data_ready, 1'b1);
        void'(sb_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", tx_data_ready, 1'b1);
        send(1'b0, 8'h81, 1'b0, waited);
        check_frame(1'b0, 8'h81, "post_rst_81");
        @(negedge clk);
        chk("post_rst_busy", tx_busy, 1'b0);

        repeat (5) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
